// File: rtl/unidad_circuito.sv
// Fire/gas safety panel control unit: synchronizes sensors, latches hazard events
// until acknowledged, drives actuators and a scanned 4-digit 7-segment display.
module unidad_circuito #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       humoa,
  input  logic       glp,
  input  logic       humom,
  input  logic       fe,
  input  logic       apagsis,
  output logic [5:0] registro_salidas,
  output logic [3:0] AN,
  output logic [6:0] CN
);

  // Dwell per digit, clamped to at most one second and at least one cycle.
  localparam int unsigned SCAN_CLAMP = (SCAN_DIV > CLK_HZ) ? CLK_HZ : SCAN_DIV;
  localparam int unsigned SCAN_EFF   = (SCAN_CLAMP == 0) ? 1 : SCAN_CLAMP;
  localparam int unsigned SCAN_LAST  = SCAN_EFF - 1;
  localparam int unsigned CNT_W      = (SCAN_EFF > 1) ? $clog2(SCAN_EFF) : 1;
  localparam int unsigned IN_W       = 5;
  localparam int unsigned FLAG_W     = 4;

  localparam logic [6:0] GLYPH_ONE  = 7'b1111001;
  localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

  // Raw input bundle: {apagsis, humoa, glp, humom, fe}
  logic [IN_W-1:0]   raw_in;
  logic [IN_W-1:0]   s1_q, s2_q;
  logic [FLAG_W-1:0] sens_s;
  logic              apag_s;

  // Flag bits: [3]=F_HA, [2]=F_GLP, [1]=F_HM, [0]=F_FE (also digit index order)
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        cn_q, cn_d;
  logic              two_plus;

  assign raw_in = {apagsis, humoa, glp, humom, fe};
  assign sens_s = s2_q[FLAG_W-1:0];
  assign apag_s = s2_q[IN_W-1];

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      cn_q    <= 7'b1111111;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      cn_q    <= cn_d;
    end
  end

  // Acknowledge wins over any sensor seen on the same edge.
  always_comb begin
    flags_d = flags_q | sens_s;
    if (apag_s) begin
      flags_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_LAST)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d = ~(4'b0001 << idx_q);
    cn_d = flags_q[idx_q] ? GLYPH_ONE : GLYPH_ZERO;
  end

  assign two_plus = (flags_q[0] & flags_q[1]) | (flags_q[0] & flags_q[2]) |
                    (flags_q[0] & flags_q[3]) | (flags_q[1] & flags_q[2]) |
                    (flags_q[1] & flags_q[3]) | (flags_q[2] & flags_q[3]);

  assign registro_salidas[0] = |flags_q;
  assign registro_salidas[1] = flags_q[3] | flags_q[0];
  assign registro_salidas[2] = flags_q[2];
  assign registro_salidas[3] = flags_q[1] | flags_q[2];
  assign registro_salidas[4] = flags_q[2] | flags_q[0];
  assign registro_salidas[5] = flags_q[0] | two_plus;

  assign AN = an_q;
  assign CN = cn_q;

endmodule

// File: tb/tb_unidad_circuito.sv
// Scoreboard bench for unidad_circuito: expected actuator and display values are
// queued when stimulus is applied and compared once the DUT latency has elapsed.
module tb_unidad_circuito;

  localparam int unsigned SD = 8;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G0 = 7'b1000000;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       humoa, glp, humom, fe, apagsis;
  logic [5:0] registro_salidas;
  logic [3:0] AN;
  logic [6:0] CN;

  int total = 0;
  int bad   = 0;

  logic [5:0]  q_sal[$];
  logic [10:0] q_disp[$];
  logic [5:0]  cur_exp;

  unidad_circuito #(.CLK_HZ(100_000_000), .SCAN_DIV(SD)) dut (
    .clk1(clk1), .reset(reset), .humoa(humoa), .glp(glp), .humom(humom),
    .fe(fe), .apagsis(apagsis), .registro_salidas(registro_salidas),
    .AN(AN), .CN(CN)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Drive {humoa,glp,humom,fe} and apagsis; output must hold for 2 edges, update on the 3rd.
  task automatic drive(input string tag, input logic [3:0] sens, input logic apag,
                       input logic [5:0] exp);
    logic [5:0] e;
    @(negedge clk1);
    {humoa, glp, humom, fe} = sens;
    apagsis = apag;
    q_sal.push_back(exp);
    repeat (2) @(posedge clk1);
    #1 chk({tag, "_hold"}, 32'(registro_salidas), 32'(cur_exp));
    @(posedge clk1);
    #1 e = q_sal.pop_front();
    chk(tag, 32'(registro_salidas), 32'(e));
    cur_exp = e;
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp_cn);
    logic [3:0] target;
    bit found;
    target = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 6 * SD; i++) begin
      @(posedge clk1);
      #1;
      if (AN === target) begin
        found = 1;
        break;
      end
    end
    if (!found) chk({tag, "_timeout"}, 32'(AN), 32'(target));
    else chk(tag, 32'(CN), 32'(exp_cn));
  endtask

  // Full scan from digit 0 right after reset release, flags all clear.
  task automatic scan_check();
    logic [3:0]  last_an;
    logic [10:0] e;
    int dwell, seen;
    q_disp.push_back({4'b1110, G0});
    q_disp.push_back({4'b1101, G0});
    q_disp.push_back({4'b1011, G0});
    q_disp.push_back({4'b0111, G0});
    q_disp.push_back({4'b1110, G0});
    last_an = AN;
    dwell = 0;
    seen = 0;
    for (int i = 0; i < 6 * SD && q_disp.size() > 0; i++) begin
      @(posedge clk1);
      #1;
      dwell++;
      if (AN !== last_an) begin
        e = q_disp.pop_front();
        chk("scan_an", 32'(AN), 32'(e[10:7]));
        chk("scan_cn", 32'(CN), 32'(e[6:0]));
        if (seen > 0) chk("scan_dwell", 32'(dwell), 32'(SD));
        dwell = 0;
        last_an = AN;
        seen++;
      end
    end
    if (q_disp.size() != 0) chk("scan_timeout", 32'(q_disp.size()), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {humoa, glp, humom, fe, apagsis} = '0;
    cur_exp = '0;
    repeat (5) @(posedge clk1);
    #1;
    chk("rst_sal", 32'(registro_salidas), 32'h00);
    chk("rst_an", 32'(AN), 32'hf);
    chk("rst_cn", 32'(CN), 32'h7f);

    @(negedge clk1);
    reset = 1'b0;
    scan_check();

    drive("ha_set", 4'b1000, 1'b0, 6'b000011);
    drive("ha_held", 4'b0000, 1'b0, 6'b000011);
    check_digit("d3_ha", 3, G1);
    check_digit("d2_ha", 2, G0);

    drive("ack1", 4'b0000, 1'b1, 6'b000000);
    drive("ack1_rel", 4'b0000, 1'b0, 6'b000000);
    drive("glp_set", 4'b0100, 1'b0, 6'b011101);

    drive("ack2", 4'b0000, 1'b1, 6'b000000);
    drive("ack2_rel", 4'b0000, 1'b0, 6'b000000);
    drive("hm_set", 4'b0010, 1'b0, 6'b001001);
    drive("hm_held", 4'b0000, 1'b0, 6'b001001);
    drive("hm_fe", 4'b0001, 1'b0, 6'b111011);
    check_digit("d1_hm", 1, G1);
    check_digit("d0_fe", 0, G1);

    drive("ack3", 4'b0000, 1'b1, 6'b000000);
    drive("ack3_rel", 4'b0000, 1'b0, 6'b000000);
    drive("ha_glp", 4'b1100, 1'b0, 6'b111111);
    check_digit("d3_both", 3, G1);
    check_digit("d2_both", 2, G1);
    check_digit("d1_both", 1, G0);
    check_digit("d0_both", 0, G0);

    drive("ack_glp", 4'b0100, 1'b1, 6'b000000);
    drive("ack_glp_hold", 4'b0100, 1'b1, 6'b000000);
    check_digit("d2_acked", 2, G0);
    drive("glp_reset", 4'b0100, 1'b0, 6'b011101);

    @(negedge clk1);
    reset = 1'b1;
    #1;
    chk("mid_rst_sal", 32'(registro_salidas), 32'h00);
    chk("mid_rst_an", 32'(AN), 32'hf);
    chk("mid_rst_cn", 32'(CN), 32'h7f);
    {humoa, glp, humom, fe, apagsis} = '0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    reset = 1'b0;
    cur_exp = '0;
    drive("post_rst", 4'b0000, 1'b0, 6'b000000);
    check_digit("d2_post", 2, G0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
